meas_bcd_conv: RTL and testbench

Measurement-to-display formatter sitting directly upstream of the VGA rendering top. It snapshots the eight 16-bit measurement results (sine/non-sine frequency and amplitude, 2nd–5th harmonic amplitudes) on an update strobe. It converts each result to 5-digit packed BCD with a sequential shift-add-3 engine and publishes all eight results atomically with leading-zero blanking flags. The character renderer uses these flags to index the digit ROM. Runs entirely in the 106 MHz pixel-clock domain.

---
 rtl/meas_bcd_conv.sv | 243 ++++++++++++++++++++++++
 tb/tb_meas_bcd_conv.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_bcd_conv.sv
// -----------------------------------------------------------------------------
// meas_bcd_conv
//
// Measurement-to-display formatter in the pixel-clock domain. On an update
// request it snapshots eight binary measurement results, converts each one to
// five packed BCD digits using a sequential shift-add-3 engine, and then
// publishes all eight results at once, together with leading-zero blanking
// flags for the character renderer.
//
// Ports:
//   clk      in   pixel-domain clock
//   rst      in   synchronous, active-high reset
//   upd      in   update request; only acted on while idle
//   zx_P .. fzx_5_F  in  W-bit binary results, channels 0..7 in that order
//   bcd_out  out  packed BCD; channel c at [c*20+19:c*20], digit 0 = units
//   lz_mask  out  blank flags; channel c at [c*5+4:c*5], bit d = leading zero
//   busy     out  conversion in progress
//   done     out  one-cycle pulse in the cycle that bcd_out/lz_mask update
//
// Timing: if upd is sampled at edge k, done and the new outputs appear after
// edge k+145, and busy drops in the same cycle. Each channel takes 18 cycles
// (1 load, 16 shift, 1 store), and one more cycle commits the outputs.
// -----------------------------------------------------------------------------
module meas_bcd_conv #(
  parameter int NCH = 8,
  parameter int W   = 16,
  parameter int ND  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd,
  input  logic [W-1:0]          zx_P,
  input  logic [W-1:0]          zx_F,
  input  logic [W-1:0]          fzx_P,
  input  logic [W-1:0]          fzx_F,
  input  logic [W-1:0]          fzx_2_F,
  input  logic [W-1:0]          fzx_3_F,
  input  logic [W-1:0]          fzx_4_F,
  input  logic [W-1:0]          fzx_5_F,
  output logic [NCH*ND*4-1:0]   bcd_out,
  output logic [NCH*ND-1:0]     lz_mask,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = ND * 4;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);
  localparam logic [CW-1:0] CH_ONE    = CW'(1);
  localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);
  localparam logic [IW-1:0] ITER_ONE  = IW'(1);

  // Blank pattern for a value of zero: every digit except units is blanked
  localparam logic [ND-1:0] LZ_RST = {{(ND-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]       w_in [NCH];
  logic [W-1:0]       r_snap [NCH];
  logic [BW-1:0]      r_shadow [NCH];
  logic [W-1:0]       r_bin_sr;
  logic [BW-1:0]      r_bcd_sr;
  logic [IW-1:0]      r_iter;
  logic [CW-1:0]      r_ch;
  logic [BW-1:0]      w_bcd_adj;
  logic [NCH*BW-1:0]  w_shadow_flat;
  logic [NCH*ND-1:0]  w_lz_flat;
  logic [NCH*BW-1:0]  r_bcd_out;
  logic [NCH*ND-1:0]  r_lz_mask;
  logic               r_busy;
  logic               r_done;

  // Add-3 correction: any nibble of 5 or more would exceed 9 after doubling
  function automatic logic [BW-1:0] bcd_adj(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int d = 0; d < ND; d++) begin
      if (v[d*4 +: 4] >= 4'd5) begin
        r[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
      end else begin
        r[d*4 +: 4] = v[d*4 +: 4];
      end
    end
    return r;
  endfunction

  // Leading-zero flags: digit d is blank when it and every higher digit are
  // zero. Units is never blank, so that a value of 0 still shows one digit.
  function automatic logic [ND-1:0] lz_of(input logic [BW-1:0] v);
    logic [ND-1:0] m;
    logic          z;
    m = {ND{1'b0}};
    z = 1'b1;
    for (int d = ND - 1; d >= 1; d--) begin
      z    = z & (v[d*4 +: 4] == 4'd0);
      m[d] = z;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  assign w_in[0] = zx_P;
  assign w_in[1] = zx_F;
  assign w_in[2] = fzx_P;
  assign w_in[3] = fzx_F;
  assign w_in[4] = fzx_2_F;
  assign w_in[5] = fzx_3_F;
  assign w_in[6] = fzx_4_F;
  assign w_in[7] = fzx_5_F;

  assign w_bcd_adj = bcd_adj(r_bcd_sr);

  // Flatten the shadow bank and derive blank flags from it for the commit
  always_comb begin
    w_shadow_flat = {(NCH*BW){1'b0}};
    w_lz_flat     = {(NCH*ND){1'b0}};
    for (int c = 0; c < NCH; c++) begin
      w_shadow_flat[c*BW +: BW] = r_shadow[c];
      w_lz_flat[c*ND +: ND]     = lz_of(r_shadow[c]);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state: per channel load -> 16 shifts -> store, then commit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (upd) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_iter == ITER_LAST) begin
          w_state_nxt = ST_STORE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_STORE: begin
        if (r_ch == CH_LAST) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: snapshot bank, conversion engine, shadow bank and output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_snap[c]   <= {W{1'b0}};
        r_shadow[c] <= {BW{1'b0}};
      end
      r_bin_sr  <= {W{1'b0}};
      r_bcd_sr  <= {BW{1'b0}};
      r_iter    <= {IW{1'b0}};
      r_ch      <= {CW{1'b0}};
      r_bcd_out <= {(NCH*BW){1'b0}};
      r_lz_mask <= {NCH{LZ_RST}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Inputs are captured only here; later changes do not matter
          if (upd) begin
            for (int c = 0; c < NCH; c++) begin
              r_snap[c] <= w_in[c];
            end
            r_ch   <= {CW{1'b0}};
            r_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_bin_sr <= r_snap[r_ch];
          r_bcd_sr <= {BW{1'b0}};
          r_iter   <= {IW{1'b0}};
        end
        ST_SHIFT: begin
          // The binary MSB moves into the BCD LSB
          {r_bcd_sr, r_bin_sr} <= {w_bcd_adj, r_bin_sr} << 1'b1;
          r_iter <= r_iter + ITER_ONE;
        end
        ST_STORE: begin
          r_shadow[r_ch] <= r_bcd_sr;
          if (r_ch != CH_LAST) begin
            r_ch <= r_ch + CH_ONE;
          end
        end
        ST_COMMIT: begin
          // All channels become visible in one edge, never a partial set
          r_bcd_out <= w_shadow_flat;
          r_lz_mask <= w_lz_flat;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out = r_bcd_out;
  assign lz_mask = r_lz_mask;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_meas_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_meas_bcd_conv
//
// Self-checking bench for meas_bcd_conv. The reference is plain decimal
// arithmetic: the BCD digits come from repeated division by 10, and the blank
// flag for digit d comes from "value < 10**d".
// -----------------------------------------------------------------------------
module tb_meas_bcd_conv;

  logic          clk;
  logic          rst;
  logic          upd;
  logic [15:0]   zx_P, zx_F, fzx_P, fzx_F, fzx_2_F, fzx_3_F, fzx_4_F, fzx_5_F;
  logic [159:0]  bcd_out;
  logic [39:0]   lz_mask;
  logic          busy;
  logic          done;

  int            n_checks;
  int            n_errors;
  int            vals [8];

  meas_bcd_conv dut (
    .clk     (clk),
    .rst     (rst),
    .upd     (upd),
    .zx_P    (zx_P),
    .zx_F    (zx_F),
    .fzx_P   (fzx_P),
    .fzx_F   (fzx_F),
    .fzx_2_F (fzx_2_F),
    .fzx_3_F (fzx_3_F),
    .fzx_4_F (fzx_4_F),
    .fzx_5_F (fzx_5_F),
    .bcd_out (bcd_out),
    .lz_mask (lz_mask),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    r = 20'd0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_lz(input int v);
    logic [4:0] m;
    int p;
    m = 5'd0;
    p = 10;
    for (int d = 1; d < 5; d++) begin
      m[d] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  function automatic logic [159:0] exp_bcd_all();
    logic [159:0] r;
    r = 160'd0;
    for (int c = 0; c < 8; c++) r[c*20 +: 20] = ref_bcd(vals[c]);
    return r;
  endfunction

  function automatic logic [39:0] exp_lz_all();
    logic [39:0] r;
    r = 40'd0;
    for (int c = 0; c < 8; c++) r[c*5 +: 5] = ref_lz(vals[c]);
    return r;
  endfunction

  task automatic drive_vals();
    zx_P = 16'(vals[0]); zx_F = 16'(vals[1]); fzx_P = 16'(vals[2]); fzx_F = 16'(vals[3]);
    fzx_2_F = 16'(vals[4]); fzx_3_F = 16'(vals[5]); fzx_4_F = 16'(vals[6]); fzx_5_F = 16'(vals[7]);
  endtask

  task automatic drive_sevens();
    zx_P = 16'd7; zx_F = 16'd7; fzx_P = 16'd7; fzx_F = 16'd7;
    fzx_2_F = 16'd7; fzx_3_F = 16'd7; fzx_4_F = 16'd7; fzx_5_F = 16'd7;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_bcd"}, bcd_out, 160'd0);
    check_eq({tag, "_lz"}, 160'(lz_mask), 160'({8{5'b11110}}));
    check_eq({tag, "_busy"}, 160'(busy), 160'd0);
    check_eq({tag, "_done"}, 160'(done), 160'd0);
  endtask

  // mode 0: plain, 1: inputs scrambled after snapshot, 2: upd re-pulsed while busy
  task automatic run_conv(input string tag, input int mode);
    logic [159:0] prev_bcd;
    logic [39:0]  prev_lz;
    bit stable;
    bit got;
    int n;
    int extra_done;
    int extra_busy;
    prev_bcd = bcd_out;
    prev_lz  = lz_mask;
    stable   = 1'b1;
    got      = 1'b0;
    @(negedge clk);
    drive_vals();
    upd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd = 1'b0;
    n = 0;
    check_eq({tag, "_busy_start"}, 160'(busy), 160'd1);
    while (!got && n < 200) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (bcd_out !== prev_bcd || lz_mask !== prev_lz) stable = 1'b0;
        if (mode == 1) drive_sevens();
        if (mode == 2) upd = (n == 10 || n == 100);
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    upd = 1'b0;
    check_eq({tag, "_latency"}, 160'(n), 160'd145);
    check_eq({tag, "_hold"}, 160'(stable), 160'd1);
    check_eq({tag, "_bcd"}, bcd_out, exp_bcd_all());
    check_eq({tag, "_lz"}, 160'(lz_mask), 160'(exp_lz_all()));
    check_eq({tag, "_busy_end"}, 160'(busy), 160'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 160'(done), 160'd0);
    if (mode == 2) begin
      extra_done = 0;
      extra_busy = 0;
      for (int i = 0; i < 160; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) extra_done++;
        if (busy) extra_busy++;
      end
      check_eq({tag, "_no_second_done"}, 160'(extra_done), 160'd0);
      check_eq({tag, "_no_second_busy"}, 160'(extra_busy), 160'd0);
    end
  endtask

  initial begin
    int dones;
    int t;
    int last_t;
    int period_bad;
    int ch0_bad;
    int cur;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    upd = 1'b0;
    for (int c = 0; c < 8; c++) vals[c] = 0;
    drive_vals();

    // Reset held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Directed vector covering digit-count boundaries
    vals = '{12345, 0, 65535, 9, 10, 99, 100, 50000};
    run_conv("directed", 0);

    // Snapshot isolation: inputs go to 7 right after the snapshot
    for (int c = 0; c < 8; c++) vals[c] = $urandom_range(0, 65535);
    run_conv("isolation", 1);

    // Requests while busy are ignored
    for (int c = 0; c < 8; c++) vals[c] = $urandom_range(0, 9999);
    run_conv("repulse", 2);

    // Reset in the middle of a conversion
    for (int c = 0; c < 8; c++) vals[c] = $urandom_range(1, 65535);
    @(negedge clk);
    drive_vals();
    upd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd = 1'b0;
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("midreset_no_done", 160'(dones), 160'd0);
    run_conv("after_reset", 0);

    // Random conversions, mixing full-range and short values
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        vals[c] = (($urandom_range(0, 1)) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 120);
      end
      run_conv("random", 0);
    end

    // upd held high: back-to-back conversions, zx_P advancing each time
    vals = '{40000, 1, 2, 3, 4, 5, 6, 7};
    @(negedge clk);
    drive_vals();
    upd = 1'b1;
    cur = 40000;
    dones = 0;
    t = 0;
    last_t = 0;
    period_bad = 0;
    ch0_bad = 0;
    while (dones < 3 && t < 600) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (done) begin
        if (t - last_t != 146) period_bad++;
        if (bcd_out[19:0] !== ref_bcd(cur)) ch0_bad++;
        last_t = t;
        dones++;
        cur = cur + 1234;
        zx_P = 16'(cur);
        if (dones == 3) upd = 1'b0;
      end
    end
    upd = 1'b0;
    check_eq("stream_dones", 160'(dones), 160'd3);
    check_eq("stream_period", 160'(period_bad), 160'd0);
    check_eq("stream_ch0", 160'(ch0_bad), 160'd0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check_eq("stream_idle", 160'(busy), 160'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
